// File: rtl/bldc_pkg.sv
// bldc_pkg: request encoding, forward commutation table and invalid hall codes
package bldc_pkg;
    localparam logic [1:0] REQ_OFF = 2'b00;
    localparam logic [1:0] REQ_H   = 2'b01;
    localparam logic [1:0] REQ_L   = 2'b10;
    localparam logic [2:0] HALL_BAD0 = 3'b000;
    localparam logic [2:0] HALL_BAD1 = 3'b111;
    // {hall, high phase one-hot {C,B,A}, low phase one-hot {C,B,A}}, forward rotation
    localparam logic [8:0] COMM_TBL [6] = '{
        {3'b101, 3'b001, 3'b010},
        {3'b100, 3'b001, 3'b100},
        {3'b110, 3'b010, 3'b100},
        {3'b010, 3'b010, 3'b001},
        {3'b011, 3'b100, 3'b001},
        {3'b001, 3'b100, 3'b010}
    };
    function automatic logic [5:0] comm_decode(input logic [2:0] h, input logic d);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++)
            if (COMM_TBL[i][8:6] == h)
                r = d ? {COMM_TBL[i][2:0], COMM_TBL[i][5:3]} : COMM_TBL[i][5:0];
        return r;
    endfunction
endpackage

// File: rtl/bldc_commutator_deadtime.sv
// deadtime_phase: one half-bridge; any request change blanks both gates for DEADTIME cycles
module deadtime_phase
    import bldc_pkg::*;
#(
    parameter int DEADTIME = 8,
    parameter int DT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic       o_gh,
    output logic       o_gl
);
    logic [1:0]      r_req;
    logic [DT_W-1:0] r_cnt;
    logic            w_chg;
    logic [DT_W-1:0] w_cnt;

    always_comb begin
        w_chg = i_req != r_req;
        w_cnt = w_chg ? DT_W'(DEADTIME) : (r_cnt != '0 ? r_cnt - DT_W'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= REQ_OFF;
            r_cnt <= DT_W'(DEADTIME);
            o_gh  <= 1'b0;
            o_gl  <= 1'b0;
        end else begin
            r_req <= i_req;
            r_cnt <= w_cnt;
            o_gh  <= !w_chg && w_cnt == '0 && i_req == REQ_H;
            o_gl  <= !w_chg && w_cnt == '0 && i_req == REQ_L;
        end
    end
endmodule

// File: rtl/bldc_commutator.sv
// bldc_commutator: hall sync/filter, six-step decode with PWM chop, dead time and faults
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEADTIME  = 8,
    parameter int DT_W      = 8,
    parameter int HALL_FILT = 3,
    parameter int STALL_CYC = 1000000,
    parameter int STALL_W   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_pwm,
    input  logic       i_dir,
    input  logic       i_brake,
    input  logic [2:0] i_hall,
    input  logic       i_fault_clr,
    output logic [2:0] o_gate_h,
    output logic [2:0] o_gate_l,
    output logic       o_hall_edge,
    output logic       o_fault_hall,
    output logic       o_fault_stall
);
    localparam int FW = $clog2(HALL_FILT + 1);

    logic [2:0]         r_sync1, r_sync2, r_last, r_hall_f;
    logic [FW-1:0]      r_run;
    logic               r_valid;
    logic [STALL_W-1:0] r_stall;
    logic [FW-1:0]      w_run;
    logic               w_acc, w_edge, w_fault, w_hall_set, w_stall_clr;
    logic [STALL_W-1:0] w_stall;
    logic [5:0]         w_comm;
    logic [2:0][1:0]    w_req;

    always_comb begin
        // w_run counts the current synchronised sample, so acceptance lands on the HALL_FILT-th
        w_run = r_sync2 != r_last ? FW'(1) : (r_run == FW'(HALL_FILT) ? r_run : r_run + FW'(1));
        w_acc = w_run == FW'(HALL_FILT);
        w_edge = w_acc && r_sync2 != r_hall_f;
        w_fault = o_fault_hall || o_fault_stall;
        w_hall_set = i_en && r_valid && (r_hall_f == HALL_BAD0 || r_hall_f == HALL_BAD1);
        w_stall_clr = w_edge || !i_en || i_brake || w_fault;
        w_stall = w_stall_clr ? '0 : (r_stall == '1 ? r_stall : r_stall + STALL_W'(1));
        w_comm = comm_decode(r_hall_f, i_dir);
        w_req = '0;
        for (int k = 0; k < 3; k++)
            w_req[k] = (w_fault || (!i_en && !i_brake)) ? REQ_OFF :
                       i_brake ? REQ_L :
                       w_comm[3+k] ? (i_pwm ? REQ_H : REQ_OFF) :
                       w_comm[k] ? REQ_L : REQ_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_last        <= '0;
            r_run         <= '0;
            r_hall_f      <= '0;
            r_valid       <= 1'b0;
            r_stall       <= '0;
            o_hall_edge   <= 1'b0;
            o_fault_hall  <= 1'b0;
            o_fault_stall <= 1'b0;
        end else begin
            r_sync1       <= i_hall;
            r_sync2       <= r_sync1;
            r_last        <= r_sync2;
            r_run         <= w_run;
            r_hall_f      <= w_acc ? r_sync2 : r_hall_f;
            r_valid       <= r_valid || w_acc;
            r_stall       <= w_stall;
            o_hall_edge   <= w_edge;
            o_fault_hall  <= w_hall_set || (o_fault_hall && !i_fault_clr);
            o_fault_stall <= w_stall >= STALL_W'(STALL_CYC) || (o_fault_stall && !i_fault_clr);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_phase
        deadtime_phase #(.DEADTIME(DEADTIME), .DT_W(DT_W)) u_dt (
            .clk  (clk),
            .rst  (rst),
            .i_req(w_req[g]),
            .o_gh (o_gate_h[g]),
            .o_gl (o_gate_l[g])
        );
    end
endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: directed scenarios with a queue of expected results per checkpoint
module tb_bldc_commutator;
    logic       clk, rst, en, pwm, dir, brake, fault_clr;
    logic [2:0] hall, gate_h, gate_l;
    logic       hall_edge, fault_hall, fault_stall;
    logic       overlap;
    logic [2:0] cur_h;
    logic       cur_d;
    int         n_cmp, n_err;

    typedef struct { string tag; int val; } exp_t;
    exp_t sb[$];

    bldc_commutator #(
        .DEADTIME(4), .DT_W(8), .HALL_FILT(3), .STALL_CYC(64), .STALL_W(24)
    ) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_pwm(pwm), .i_dir(dir), .i_brake(brake),
        .i_hall(hall), .i_fault_clr(fault_clr), .o_gate_h(gate_h), .o_gate_l(gate_l),
        .o_hall_edge(hall_edge), .o_fault_hall(fault_hall), .o_fault_stall(fault_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial overlap = 1'b0;
    always @(negedge clk) if ((gate_h & gate_l) != 3'b000) overlap = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    function automatic logic [5:0] tb_comm(input logic [2:0] h, input logic d);
        logic [2:0] hi, lo;
        case (h)
            3'b101: begin hi = 3'b001; lo = 3'b010; end
            3'b100: begin hi = 3'b001; lo = 3'b100; end
            3'b110: begin hi = 3'b010; lo = 3'b100; end
            3'b010: begin hi = 3'b010; lo = 3'b001; end
            3'b011: begin hi = 3'b100; lo = 3'b001; end
            3'b001: begin hi = 3'b100; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        return d ? {lo, hi} : {hi, lo};
    endfunction

    function automatic int req_of(input logic [5:0] c, input int p);
        return c[3+p] ? 1 : (c[p] ? 2 : 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input int v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0h, expected a queued entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: got %0h, expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic ck(input string t, input int obs, input int v);
        push(t, v);
        pop_chk(obs);
    endtask

    task automatic wait_edge(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!hall_edge && k < 20);
    endtask

    task automatic do_step(input logic [2:0] nh, input logic nd);
        logic [5:0] o, n;
        logic [2:0] chg, mask, clr;
        int k, dead;
        o = tb_comm(cur_h, cur_d);
        n = tb_comm(nh, nd);
        chg = '0;
        for (int p = 0; p < 3; p++) if (req_of(o, p) != req_of(n, p)) chg[p] = 1'b1;
        mask = chg & (n[5:3] | n[2:0]);
        if (nh != cur_h) push("step_latency", 5);
        push("step_clear", 0);
        push("step_dead", 4);
        push("step_gate_h", int'(n[5:3]));
        push("step_gate_l", int'(n[2:0]));
        if (nh != cur_h) begin
            hall = nh;
            wait_edge(k);
            pop_chk(k);
        end else begin
            dir = nd;
        end
        cur_h = nh;
        cur_d = nd;
        dead = 0;
        clr = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (((gate_h | gate_l) & mask) == 3'b000) dead++;
            if (i == 1) clr = (gate_h | gate_l) & chg;
        end
        pop_chk(int'(clr));
        pop_chk(dead);
        pop_chk(int'(gate_h));
        pop_chk(int'(gate_l));
    endtask

    initial begin
        int k, cnt;
        logic l_hold;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b1; pwm = 1'b1; dir = 1'b0; brake = 1'b0; fault_clr = 1'b0;
        hall = 3'b101;
        cur_h = 3'b101;
        cur_d = 1'b0;
        repeat (3) tick();
        ck("rst_gate_h", int'(gate_h), 0);
        ck("rst_gate_l", int'(gate_l), 0);
        ck("rst_hall_edge", int'(hall_edge), 0);
        ck("rst_faults", int'({fault_hall, fault_stall}), 0);

        push("first_edge_latency", 5);
        rst = 1'b0;
        wait_edge(k);
        pop_chk(k);
        repeat (4) tick();
        ck("first_dead_gate_h", int'(gate_h), 0);
        ck("first_dead_gate_l", int'(gate_l), 0);
        tick();
        ck("first_gate_h", int'(gate_h), 3'b001);
        ck("first_gate_l", int'(gate_l), 3'b010);
        ck("first_edge_pulse_one_cycle", int'(hall_edge), 0);

        pwm = 1'b0;
        push("pwm_low_gate_h", 0);
        tick();
        pop_chk(int'(gate_h));
        repeat (9) tick();
        pwm = 1'b1;
        push("pwm_high_count", 5);
        push("pwm_low_side_held", 1);
        cnt = 0;
        l_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(gate_h[0]);
            l_hold &= gate_l[1];
            tick();
        end
        pwm = 1'b0;
        pop_chk(cnt);
        pop_chk(int'(l_hold));
        tick();
        ck("pwm_fall_off", int'(gate_h), 0);
        ck("pwm_fall_low_kept", int'(gate_l), 3'b010);

        pwm = 1'b1;
        repeat (5) tick();
        ck("glitch_pre_gate_h", int'(gate_h), 3'b001);
        hall = 3'b100;
        push("glitch_edges", 0);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) hall = 3'b101;
            tick();
            cnt += int'(hall_edge);
        end
        pop_chk(cnt);
        ck("glitch_gate_h", int'(gate_h), 3'b001);
        ck("glitch_gate_l", int'(gate_l), 3'b010);

        do_step(3'b101, 1'b1);
        do_step(3'b100, 1'b1);
        do_step(3'b110, 1'b1);
        do_step(3'b010, 1'b1);
        do_step(3'b011, 1'b1);
        do_step(3'b001, 1'b1);
        do_step(3'b101, 1'b1);

        hall = 3'b111;
        push("bad_hall_latency", 5);
        wait_edge(k);
        pop_chk(k);
        repeat (2) tick();
        ck("fault_hall_set", int'(fault_hall), 1);
        ck("fault_hall_gates", int'({gate_h, gate_l}), 0);
        fault_clr = 1'b1;
        push("fault_clr_set_wins", 1);
        tick();
        fault_clr = 1'b0;
        pop_chk(int'(fault_hall));
        hall = 3'b101;
        wait_edge(k);
        ck("fault_recover_latency", k, 5);
        repeat (2) tick();
        ck("fault_hall_sticky", int'(fault_hall), 1);
        ck("fault_sticky_gates", int'({gate_h, gate_l}), 0);
        fault_clr = 1'b1;
        push("fault_hall_cleared", 0);
        tick();
        fault_clr = 1'b0;
        pop_chk(int'(fault_hall));
        repeat (4) tick();
        ck("post_clr_dead", int'({gate_h, gate_l}), 0);
        tick();
        ck("post_clr_gate_h", int'(gate_h), 3'b010);
        ck("post_clr_gate_l", int'(gate_l), 3'b001);

        hall = 3'b100;
        wait_edge(k);
        ck("stall_edge_latency", k, 5);
        push("stall_cycles", 64);
        k = 0;
        while (!fault_stall && k < 100) begin
            tick();
            k++;
        end
        pop_chk(k);
        tick();
        ck("stall_gates_off", int'({gate_h, gate_l}), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        ck("stall_cleared", int'(fault_stall), 0);

        hall = 3'b110;
        wait_edge(k);
        ck("brake_edge_latency", k, 5);
        repeat (40) tick();
        brake = 1'b1;
        push("brake_gate_l", 3'b111);
        push("brake_gate_h", 0);
        repeat (5) tick();
        pop_chk(int'(gate_l));
        pop_chk(int'(gate_h));
        repeat (45) tick();
        ck("brake_no_stall", int'(fault_stall), 0);
        ck("brake_gate_l_held", int'(gate_l), 3'b111);
        brake = 1'b0;
        repeat (6) tick();
        ck("unbrake_gate_h", int'(gate_h), 3'b100);
        ck("unbrake_gate_l", int'(gate_l), 3'b010);
        ck("unbrake_no_stall", int'(fault_stall), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        ck("midrst_gates", int'({gate_h, gate_l}), 0);
        ck("midrst_flags", int'({hall_edge, fault_hall, fault_stall}), 0);
        ck("no_shoot_through", int'(overlap), 0);
        ck("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
